ms_result_fifo: RTL and testbench

- Downstream capture stage for the MainSource datapath (x_in/flag -> y_out).
- Samples MainSource's 8-bit y_out together with the flag that produced it, on a capture strobe.
- Stores each {flag, y} pair in a small synchronous FIFO so a slower consumer (display/readback logic, or the bench) can drain results in order.
- Single clock domain; flags overflow/underflow errors.

---
 rtl/ms_pkg.sv | 12 +
 rtl/ms_fifo_mem.sv | 39 +++
 rtl/ms_result_fifo.sv | 128 ++++++++++++
 tb/tb_ms_result_fifo.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_pkg.sv
// Shared types and constants for the MainSource result capture path.
package ms_pkg;

  localparam int MS_DATA_W     = 8;
  localparam int MS_FIFO_DEPTH = 8;

  typedef struct packed {
    logic                 flag;
    logic [MS_DATA_W-1:0] y;
  } ms_result_t;

endpackage

// File: rtl/ms_fifo_mem.sv
// DEPTH x ms_result_t storage with one write port and a registered read port.
module ms_fifo_mem
  import ms_pkg::*;
#(
  parameter int DEPTH = MS_FIFO_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  ms_result_t       wr_data,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_addr,
  output ms_result_t       rd_data
);

  ms_result_t mem [DEPTH];
  ms_result_t rd_q;
  ms_result_t rd_d;

  // Storage itself is never reset; only the read-out register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_d = rd_q;
    if (rd_en) rd_d = mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/ms_result_fifo.sv
// Capture FIFO for {flag, y_out} results with sticky overflow/underflow flags.
// Optional flag-only capture filter: define MS_RESULT_FIFO_FLAG_FILTER_EN.
module ms_result_fifo
  import ms_pkg::*;
#(
  parameter int DATA_W = MS_DATA_W,
  parameter int DEPTH  = MS_FIFO_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] y_in,
  input  logic              flag_in,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clr,
`ifdef MS_RESULT_FIFO_FLAG_FILTER_EN
  input  logic              cap_flag_only,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_flag,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              udf
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_req, wr_ok, rd_ok;
  logic             empty_w, full_w;
  ms_result_t       wr_res, rd_res;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULL_CNT);

`ifdef MS_RESULT_FIFO_FLAG_FILTER_EN
  // Filtered-out strobes behave as if wr_en was never raised.
  assign wr_req = wr_en && (flag_in || !cap_flag_only);
`else
  assign wr_req = wr_en;
`endif

  // A read frees a slot on the same edge, so full plus rd_en still accepts.
  assign wr_ok = wr_req && (!full_w || rd_en) && !clr;
  assign rd_ok = rd_en && !empty_w && !clr;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    rd_valid_d = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (wr_req && full_w && !rd_en) ovf_d = 1'b1;
      if (rd_en && empty_w)           udf_d = 1'b1;
      rd_valid_d = rd_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign wr_res.flag = flag_in;
  assign wr_res.y    = y_in;

  ms_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_res),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_res)
  );

  assign rd_data  = rd_res.y;
  assign rd_flag  = rd_res.flag;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: tb/tb_ms_result_fifo.sv
// Self-checking bench for ms_result_fifo against a queue-based reference model.
module tb_ms_result_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] y_in = '0;
  logic       flag_in = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr = 1'b0;
`ifdef MS_RESULT_FIFO_FLAG_FILTER_EN
  logic       cap_flag_only = 1'b0;
`endif
  logic [7:0] rd_data;
  logic       rd_flag, rd_valid, empty, full, ovf, udf;
  logic [3:0] count;

  ms_result_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .y_in     (y_in),
    .flag_in  (flag_in),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .clr      (clr),
`ifdef MS_RESULT_FIFO_FLAG_FILTER_EN
    .cap_flag_only (cap_flag_only),
`endif
    .rd_data  (rd_data),
    .rd_flag  (rd_flag),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .ovf      (ovf),
    .udf      (udf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: ordered queue of {flag, y} plus sticky flags and last pop.
  logic [8:0] q[$];
  logic       m_ovf = 1'b0, m_udf = 1'b0, m_vld = 1'b0, m_flag = 1'b0;
  logic [7:0] m_data = '0;

  wire [17:0] obs = {rd_valid, rd_flag, rd_data, count, empty, full, ovf, udf};

  function automatic logic [17:0] exp_vec();
    int n;
    n = q.size();
    return {m_vld, m_flag, m_data, 4'(n), (n == 0), (n == DEPTH), m_ovf, m_udf};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_vld = 0; m_flag = 0; m_data = '0;
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] y,
                      input logic f, input logic c);
    int  n;
    logic wreq;
    @(negedge clk);
    wr_en = w; rd_en = r; y_in = y; flag_in = f; clr = c;
    n = q.size();
    wreq = w;
`ifdef MS_RESULT_FIFO_FLAG_FILTER_EN
    if (cap_flag_only && !f) wreq = 1'b0;
`endif
    if (c) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_vld = 0;
    end else begin
      m_vld = 0;
      if (r && n > 0) begin
        {m_flag, m_data} = q.pop_front();
        m_vld = 1;
      end
      if (r && n == 0) m_udf = 1;
      if (wreq && n == DEPTH && !r) m_ovf = 1;
      if (wreq && (n < DEPTH || r)) q.push_back({f, y});
    end
    @(posedge clk);
    #1;
    $display("t=%0t wr=%b rd=%b clr=%b y=%02h f=%b | cnt=%0d vld=%b data=%02h flag=%b ovf=%b udf=%b",
             $time, w, r, c, y, f, count, rd_valid, rd_data, rd_flag, ovf, udf);
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 0);
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_state obs=%05h exp=%05h", obs, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_release obs=%05h exp=%05h", obs, exp_vec());
    end
  endtask

  task automatic test_order();
    logic [8:0] pat [4];
    pat[0] = {1'b0, 8'h21}; pat[1] = {1'b1, 8'h01};
    pat[2] = {1'b0, 8'h0f}; pat[3] = {1'b1, 8'hf0};
    for (int i = 0; i < 4; i++) step(1, 0, pat[i][7:0], pat[i][8], 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h00, 0, 0);
      vectors++;
      if (obs !== exp_vec() || {rd_flag, rd_data} !== pat[i] || rd_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL order_read%0d obs=%05h exp=%05h want=%03h", i, obs, exp_vec(), pat[i]);
      end
    end
    idle();
    vectors++;
    if (obs !== exp_vec() || empty !== 1'b1 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL order_drained obs=%05h exp=%05h", obs, exp_vec());
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) step(1, 0, 8'(i), 0, 0);
    step(1, 0, 8'hAA, 1, 0);
    vectors++;
    if (obs !== exp_vec() || full !== 1'b1 || count !== 4'd8 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow obs=%05h exp=%05h", obs, exp_vec());
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'h00, 0, 0);
      vectors++;
      if (obs !== exp_vec() || rd_data !== 8'(i)) begin
        miscompares++;
        $display("FAIL overflow_drain%0d got=%02h want=%02h obs=%05h exp=%05h",
                 i, rd_data, 8'(i), obs, exp_vec());
      end
    end
    step(0, 0, 8'h00, 0, 1);
    vectors++;
    if (obs !== exp_vec() || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clr obs=%05h exp=%05h", obs, exp_vec());
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) step(1, 0, 8'(i), 0, 0);
    step(1, 1, 8'h55, 0, 0);
    vectors++;
    if (obs !== exp_vec() || rd_data !== 8'h00 || count !== 4'd8 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL full_rw obs=%05h exp=%05h", obs, exp_vec());
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'h00, 0, 0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL full_rw_drain%0d obs=%05h exp=%05h", i, obs, exp_vec());
      end
    end
    vectors++;
    if (rd_data !== 8'h55 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL full_rw_last got=%02h want=55 empty=%b", rd_data, empty);
    end
  endtask

  task automatic test_empty_rw();
    step(1, 1, 8'h21, 0, 0);
    vectors++;
    if (obs !== exp_vec() || udf !== 1'b1 || rd_valid !== 1'b0 || count !== 4'd1) begin
      miscompares++;
      $display("FAIL empty_rw obs=%05h exp=%05h", obs, exp_vec());
    end
    step(0, 1, 8'h00, 0, 0);
    vectors++;
    if (obs !== exp_vec() || rd_data !== 8'h21 || rd_flag !== 1'b0 || rd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_rw_read obs=%05h exp=%05h", obs, exp_vec());
    end
    step(0, 0, 8'h00, 0, 1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 8'h10 + 8'(i), 1, 0);
      step(0, 1, 8'h00, 0, 0);
      vectors++;
      if (obs !== exp_vec() || rd_data !== 8'h10 + 8'(i) || rd_flag !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap%0d got=%02h want=%02h obs=%05h exp=%05h",
                 i, rd_data, 8'h10 + 8'(i), obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic w, r, c;
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 63) == 0);
      step(w, r, 8'($urandom), 1'($urandom), c);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random%0d obs=%05h exp=%05h", i, obs, exp_vec());
      end
    end
    step(0, 0, 8'h00, 0, 1);
  endtask

  task automatic test_flush();
    // Leave non-zero rd_data and a set udf before holding three entries.
    step(1, 0, 8'h77, 1, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'hC0 + 8'(i), 0, 0);
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (obs !== exp_vec() || count !== 4'd0 || empty !== 1'b1 || rd_data !== 8'h00 || udf !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset obs=%05h exp=%05h", obs, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8'h99, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'hD0 + 8'(i), 1, 0);
    step(0, 0, 8'h00, 0, 1);
    vectors++;
    if (obs !== exp_vec() || count !== 4'd0 || empty !== 1'b1 || udf !== 1'b0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_flush obs=%05h exp=%05h", obs, exp_vec());
    end
    step(1, 1, 8'hEE, 0, 1);
    vectors++;
    if (obs !== exp_vec() || count !== 4'd0 || udf !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_priority obs=%05h exp=%05h", obs, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_random();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
